twos_comp_serial_ctrl: RTL
==========================

// Module: twos_comp_serial_ctrl
// PURPOSE
//  Sequencer for the bit-serial two's-complement unit (copy-to-first-1, then invert).
//  - Accepts a parallel word over a valid/ready handshake.
//  - Streams the word LSB-first into the unit and pulses its word-start/clear input.
//  - Collects the serial result into a parallel word and presents it over valid/ready.
//  - Sits between a parallel producer/consumer and one serial complementer instance.
// PARAMETERS
//  WIDTH  8  word width in bits (>=2)
//  LAT    0  unit latency: cycles from ser_i driven to matching ser_y sampled (0 = same edge)
// PORTS
//  t_clk      in   1      system clock, all state on rising edge
//  r_n        in   1      reset, asynchronous assert, active-low
//  in_valid   in   1      in_data valid
//  in_ready   out  1      controller can accept a word
//  in_data    in   WIDTH  operand, two's complement
//  out_valid  out  1      out_data/out_ovf valid
//  out_ready  in   1      consumer accepts result
//  out_data   out  WIDTH  negated operand (mod 2^WIDTH)
//  out_ovf    out  1      operand was -2^(WIDTH-1); result equals operand
//  busy       out  1      state != IDLE
//  ser_i      out  1      serial operand bit to unit
//  ser_r      out  1      unit word-start/clear, active-high
//  ser_y      in   1      serial result bit from unit
// BEHAVIOUR
//  Reset (r_n=0, async):
//  - state=IDLE, in_ready=1, out_valid=0, out_data=0, out_ovf=0, busy=0, ser_i=0, ser_r=1.
//  FSM: IDLE -> SHIFT -> DONE -> IDLE.
//  - IDLE: in_ready=1, ser_r=1, ser_i=0.
//    in_valid&in_ready at an edge: latch word; ovf <= (in_data=={1'b1,{WIDTH-1{1'b0}}}); cnt<=0; -> SHIFT.
//  - SHIFT: runs WIDTH+LAT cycles, cnt=0..WIDTH+LAT-1; in_ready=0.
//    ser_i = word[cnt] for cnt<WIDTH, else 0. ser_r = 1 only when cnt==0.
//    At each edge with cnt>=LAT: res <= {ser_y, res[WIDTH-1:1]} (LSB-first fill).
//    Edge with cnt==WIDTH+LAT-1 -> DONE.
//  - DONE: out_valid=1; out_data=res, out_ovf=ovf, both stable while out_ready=0; ser_r=1, ser_i=0.
//    out_valid&out_ready at an edge -> IDLE, out_valid=0.
//  Handshake:
//  - Transfer only on valid&ready at a rising edge.
//  - in_ready never high outside IDLE, so no overlap with a pending result.
//  Timing:
//  - out_valid rises WIDTH+LAT cycles after the accept edge.
//  - Minimum period: WIDTH+LAT+2 cycles per word (out_ready tied high).
//  Boundaries:
//  - in_valid during SHIFT/DONE: ignored, no latch.
//  - 0 -> 0, ovf=0. Most-negative word -> itself, ovf=1.
//  - cnt width = clog2(WIDTH+LAT); no wrap beyond WIDTH+LAT-1.
//  - r_n low mid-SHIFT or mid-DONE: word and result discarded, reset values apply immediately.
//    First accept possible on the first edge after r_n deasserts.
// TESTING (bench instantiates the real serial unit; WIDTH=8)
//  1 LAT=0: 0x05 accepted -> out_valid 8 cycles later, out_data=0xFB, ovf=0;
//    ser_r high only in SHIFT cycle 0.
//  2 Sequence 0x00, 0x01, 0x7F -> 0x00, 0xFF, 0x81, all ovf=0, out_ready=1.
//    in_ready low for 9 cycles per word.
//  3 0x80 -> out_data=0x80, out_ovf=1.
//  4 Backpressure: hold out_ready=0 for 5 cycles on result 0xFB.
//    out_valid, out_data stable; in_ready=0; in_valid pulses ignored.
//  5 Reset mid-SHIFT (cnt=3, word 0x33): r_n low 1 cycle -> all outputs at reset values.
//    Then 0x2C -> 0xD4, ovf=0.
//  6 LAT=1 with a 1-cycle delayed unit: 0x05 -> 0xFB, out_valid 9 cycles after accept.

Source files
------------

// File: rtl/twos_comp_serial_ctrl_if.sv
// rtl/twos_comp_serial_ctrl_if.sv - parallel word in/out handshake bundle for the serial complementer sequencer
interface twos_comp_serial_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_ovf;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/twos_comp_serial_ctrl.sv
// rtl/twos_comp_serial_ctrl.sv - sequencer feeding a word LSB-first through a serial two's-complement unit
module twos_comp_serial_ctrl #(
    parameter int WIDTH = 8,
    parameter int LAT   = 0
) (
    input  logic                    t_clk,
    input  logic                    r_n,
    twos_comp_serial_ctrl_if.slave  bus,
    output logic                    busy,
    output logic                    ser_i,
    output logic                    ser_r,
    input  logic                    ser_y
);
    localparam int CNT_W = (WIDTH + LAT > 1) ? $clog2(WIDTH + LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH + LAT - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             ovf_q, ovf_d;
    logic             sample_en;

    // The first LAT shift cycles only prime the unit's pipeline; nothing valid comes back yet.
    generate
        if (LAT == 0) begin : g_no_lat
            assign sample_en = 1'b1;
        end else begin : g_lat
            assign sample_en = ({1'b0, cnt_q} >= (CNT_W+1)'(LAT));
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    word_d  = bus.in_data;
                    ovf_d   = (bus.in_data == MOST_NEG);
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // Word drains LSB-first; zeros follow once it is empty, covering the latency tail.
                word_d = word_q >> 1;
                if (sample_en) begin
                    res_d = {ser_y, res_q[WIDTH-1:1]};
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge t_clk or negedge r_n) begin
        if (!r_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.out_data  = res_q;
    assign bus.out_ovf   = ovf_q;
    assign busy          = (state_q != S_IDLE);
    assign ser_i         = (state_q == S_SHIFT) & word_q[0];
    // Unit is held cleared whenever it is not shifting, plus the first bit of each word.
    assign ser_r         = (state_q != S_SHIFT) | (cnt_q == '0);
endmodule
